packet_dispatcher: RTL

Distributes one AXI4-Stream packet source across the four tiles of column 0, one whole packet per tile. It is the counterpart of the column-(N-1) gatherer and sits between the host-side stream and the tile array. Packets are never split across tiles. Destination is round-robin by default, or taken from a header field when header routing is compiled in. A one-beat output register gives full TREADY backpressure handling and a registered TVALID/TDATA on every output port.

---
 rtl/dispatcher_pkg.sv | 22 ++
 rtl/axis_out_reg.sv | 74 +++++++
 rtl/packet_dispatcher.sv | 93 +++++++++
 3 files changed

// File: rtl/dispatcher_pkg.sv
// Shared types for the column-0 packet dispatcher and the column-(N-1) gatherer.
package dispatcher_pkg;

    localparam int unsigned NUM_TILES = 4;
    localparam int unsigned TILE_W    = 2;

    typedef logic [TILE_W-1:0] tile_idx_t;

    typedef enum logic {
        SOP  = 1'b0,
        BODY = 1'b1
    } disp_state_t;

    // One-hot tile select used for per-tile TVALID/TLAST vectors.
    function automatic logic [NUM_TILES-1:0] tile_onehot(input tile_idx_t t);
        logic [NUM_TILES-1:0] v;
        v = '0;
        v[t] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-beat output register with a destination tag; drives only the tagged tile
// and zeroes every other tile's TVALID/TDATA/TKEEP/TLAST.
module axis_out_reg
    import dispatcher_pkg::*;
#(
    parameter int unsigned BW  = 32,
    parameter int unsigned BWB = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_load,
    input  tile_idx_t                i_dest,
    input  logic [BW-1:0]            i_data,
    input  logic [BWB-1:0]           i_keep,
    input  logic                     i_last,
    input  logic [NUM_TILES-1:0]     i_tready,
    output logic                     o_can_load,
    output logic [NUM_TILES-1:0]     o_tvalid,
    output logic [BW*NUM_TILES-1:0]  o_tdata,
    output logic [BWB*NUM_TILES-1:0] o_tkeep,
    output logic [NUM_TILES-1:0]     o_tlast
);

    logic                     r_valid;
    tile_idx_t                r_dest;
    logic [NUM_TILES-1:0]     r_tvalid;
    logic [BW*NUM_TILES-1:0]  r_tdata;
    logic [BWB*NUM_TILES-1:0] r_tkeep;
    logic [NUM_TILES-1:0]     r_tlast;
    logic                     w_drain;

    // Only the tagged tile's TREADY can retire the held beat.
    assign w_drain    = r_valid && i_tready[r_dest];
    assign o_can_load = !r_valid || w_drain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid  <= 1'b0;
            r_dest   <= '0;
            r_tvalid <= '0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_dest  <= i_dest;
            for (int t = 0; t < NUM_TILES; t++) begin
                if (tile_idx_t'(t) == i_dest) begin
                    r_tvalid[t]           <= 1'b1;
                    r_tdata[t*BW +: BW]   <= i_data;
                    r_tkeep[t*BWB +: BWB] <= i_keep;
                    r_tlast[t]            <= i_last;
                end else begin
                    r_tvalid[t]           <= 1'b0;
                    r_tdata[t*BW +: BW]   <= '0;
                    r_tkeep[t*BWB +: BWB] <= '0;
                    r_tlast[t]            <= 1'b0;
                end
            end
        end else if (w_drain) begin
            r_valid  <= 1'b0;
            r_tvalid <= '0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= '0;
        end
    end

    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_tkeep  = r_tkeep;
    assign o_tlast  = r_tlast;

endmodule

// File: rtl/packet_dispatcher.sv
// Spreads whole AXI4-Stream packets over the four column-0 tiles.
// Define DISPATCHER_HDR_ROUTE_EN to route by TDATA[1:0] of the first beat instead of round-robin.
module packet_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int unsigned BW  = 32,
    parameter int unsigned BWB = 4
) (
    input  logic                     clk_line,
    input  logic                     rst,
    input  logic                     stream_in_packet_TVALID,
    input  logic [BW-1:0]            stream_in_packet_TDATA,
    input  logic [BWB-1:0]           stream_in_packet_TKEEP,
    input  logic                     stream_in_packet_TLAST,
    output logic                     stream_in_packet_TREADY,
    output logic [NUM_TILES-1:0]     stream_out_packet_TVALID,
    output logic [BW*NUM_TILES-1:0]  stream_out_packet_TDATA,
    output logic [BWB*NUM_TILES-1:0] stream_out_packet_TKEEP,
    output logic [NUM_TILES-1:0]     stream_out_packet_TLAST,
    input  logic [NUM_TILES-1:0]     stream_out_packet_TREADY,
    output logic [15:0]              dispatch_pkt_count
);

    disp_state_t r_state;
    tile_idx_t   r_dest_q;
    logic [15:0] r_count;
    tile_idx_t   w_route;
    tile_idx_t   w_beat_dest;
    logic        w_can_load;
    logic        w_accept;
    logic        w_accept_last;

`ifdef DISPATCHER_HDR_ROUTE_EN
    assign w_route = tile_idx_t'(stream_in_packet_TDATA[TILE_W-1:0]);
`else
    tile_idx_t r_rr;

    // Round-robin pointer advances once per completed packet.
    always_ff @(posedge clk_line) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_accept_last) begin
            r_rr <= r_rr + tile_idx_t'(1);
        end
    end

    assign w_route = r_rr;
`endif

    assign stream_in_packet_TREADY = !rst && w_can_load;
    assign w_accept      = stream_in_packet_TVALID && stream_in_packet_TREADY;
    assign w_accept_last = w_accept && stream_in_packet_TLAST;
    assign w_beat_dest   = (r_state == SOP) ? w_route : r_dest_q;

    // Packet framing FSM, latched destination and completed-packet counter.
    always_ff @(posedge clk_line) begin
        if (rst) begin
            r_state  <= SOP;
            r_dest_q <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            if (r_state == SOP) begin
                r_dest_q <= w_route;
            end
            r_state <= stream_in_packet_TLAST ? SOP : BODY;
            if (stream_in_packet_TLAST) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign dispatch_pkt_count = r_count;

    axis_out_reg #(
        .BW  (BW),
        .BWB (BWB)
    ) u_out_reg (
        .i_clk      (clk_line),
        .i_rst      (rst),
        .i_load     (w_accept),
        .i_dest     (w_beat_dest),
        .i_data     (stream_in_packet_TDATA),
        .i_keep     (stream_in_packet_TKEEP),
        .i_last     (stream_in_packet_TLAST),
        .i_tready   (stream_out_packet_TREADY),
        .o_can_load (w_can_load),
        .o_tvalid   (stream_out_packet_TVALID),
        .o_tdata    (stream_out_packet_TDATA),
        .o_tkeep    (stream_out_packet_TKEEP),
        .o_tlast    (stream_out_packet_TLAST)
    );

endmodule
